seq_detector_param: RTL and testbench

- Parametrised Moore serial-bit sequence detector, generalising the fixed 5-bit single-pattern detectors in the sequence-detector set.
- Pattern, length and overlap mode are elaboration-time parameters.
- Adds an input-valid qualifier and an optional saturating match counter.
- Sits on a serial bit stream; the match flag feeds downstream control logic.

---
 rtl/seq_det_pkg.sv | 80 ++++++++
 rtl/seq_det_sat_counter.sv | 25 ++
 rtl/seq_detector_param.sv | 96 +++++++++
 tb/tb_seq_detector_param.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and elaboration-time helpers for the parametrised sequence detector.
// The helpers build the KMP-style transition table, so no search logic exists at runtime.
package seq_det_pkg;

    localparam int unsigned MAX_SEQ_LEN = 16;

    typedef enum logic {
        NON_OVERLAP = 1'b0,
        OVERLAP     = 1'b1
    } seq_mode_t;

    // Returns the matched-prefix length after bit b arrives in state k.
    // Bit 0 of the stream is pattern[len-1].
    function automatic int next_state(
        input logic [MAX_SEQ_LEN-1:0] pattern,
        input int                     len,
        input int                     k,
        input logic                   b
    );
        logic [MAX_SEQ_LEN:0] s;
        int                   res;
        logic                 found;
        logic                 ok;
        s     = '0;
        res   = 0;
        found = 1'b0;
        for (int j = 0; j < k; j++) begin
            s[j] = pattern[len-1-j];
        end
        s[k] = b;
        if (k < len && b == pattern[len-1-k]) begin
            res   = k + 1;
            found = 1'b1;
        end
        // Longest pattern prefix that is a suffix of s[0..k]; l <= k keeps it proper.
        for (int l = k; l >= 1; l--) begin
            if (!found) begin
                ok = 1'b1;
                for (int i = 0; i < l; i++) begin
                    if (pattern[len-1-i] != s[k+1-l+i]) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    res   = l;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

    // Length of the longest proper border (prefix that is also a suffix).
    function automatic int border_len(
        input logic [MAX_SEQ_LEN-1:0] pattern,
        input int                     len
    );
        int   res;
        logic found;
        logic ok;
        res   = 0;
        found = 1'b0;
        for (int l = len - 1; l >= 1; l--) begin
            if (!found) begin
                ok = 1'b1;
                for (int i = 0; i < l; i++) begin
                    if (pattern[len-1-i] != pattern[l-1-i]) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    res   = l;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_det_sat_counter.sv
// Saturating up-counter with enable and synchronous active-low clear.
module seq_det_sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         i_clr_n,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!i_clr_n) begin
            r_cnt <= '0;
        end else if (i_en && r_cnt != MAX_VAL) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised Moore serial sequence detector with valid qualifier.
// Optional saturating match counter enabled by `define SEQ_DET_MATCH_CNT_EN.
module seq_detector_param #(
    parameter int unsigned             SEQ_LEN = 5,
    parameter logic [SEQ_LEN-1:0]      PATTERN = 5'b11001,
    parameter int unsigned             OVERLAP = 0,
    parameter int unsigned             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt
);
    import seq_det_pkg::*;

    localparam int unsigned ST_W  = $clog2(SEQ_LEN + 1);
    localparam int unsigned TBL_W = 2 * (SEQ_LEN + 1) * ST_W;

    localparam seq_mode_t MODE = (OVERLAP != 0) ? seq_det_pkg::OVERLAP
                                                : seq_det_pkg::NON_OVERLAP;
    localparam int unsigned   BORDER = border_len(MAX_SEQ_LEN'(PATTERN), SEQ_LEN);
    localparam logic [ST_W-1:0] DETECT = ST_W'(SEQ_LEN);

    generate
        if (SEQ_LEN < 2 || SEQ_LEN > MAX_SEQ_LEN) begin : g_bad_len
            $error("seq_detector_param: SEQ_LEN out of range 2..16");
        end
    endgenerate

    // Entry (2*k + b) holds the next state; DETECT reuses the border or idle row.
    function automatic logic [TBL_W-1:0] build_tbl();
        logic [TBL_W-1:0] t;
        int               src;
        t = '0;
        for (int k = 0; k <= int'(SEQ_LEN); k++) begin
            src = k;
            if (k == int'(SEQ_LEN)) begin
                src = (MODE == seq_det_pkg::OVERLAP) ? int'(BORDER) : 0;
            end
            for (int b = 0; b < 2; b++) begin
                t[(2*k+b)*ST_W +: ST_W] =
                    ST_W'(next_state(MAX_SEQ_LEN'(PATTERN), SEQ_LEN, src, b[0]));
            end
        end
        return t;
    endfunction

    localparam logic [TBL_W-1:0] TBL = build_tbl();

    logic [ST_W-1:0] r_state;
    logic            r_out;
    logic [ST_W-1:0] w_next;

    // Next-state lookup; unreachable encodings recover to idle.
    always_comb begin
        w_next = r_state;
        if (r_state > DETECT) begin
            w_next = '0;
        end else if (in_valid) begin
            w_next = TBL[(2 * 32'(r_state) + 32'(in)) * ST_W +: ST_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= '0;
            r_out   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_out   <= (w_next == DETECT);
        end
    end

    assign out = r_out;

`ifdef SEQ_DET_MATCH_CNT_EN
    logic w_hit;

    // A valid bit landing in DETECT is a new match, including DETECT->DETECT.
    assign w_hit = in_valid && (r_state <= DETECT) && (w_next == DETECT);

    seq_det_sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .i_clr_n (reset),
        .i_en    (w_hit),
        .o_cnt   (match_cnt)
    );
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param across several parameter sets.
module tb_seq_detector_param;

    localparam int NI = 5;

    logic       clk = 1'b0;
    logic       rst_n [NI];
    logic       vld   [NI];
    logic       din   [NI];
    logic       o     [NI];
    logic [7:0] cnt8  [4];
    logic [1:0] cnt2;

    int cyc    = 0;
    int tests  = 0;
    int fails  = 0;

    typedef struct {
        int   id;
        int   cyc;
        logic eo;
        int   ec;
    } exp_t;

    exp_t sb[$];
    int   qb[$];
    int   qo[$];
    int   qc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 0: 11001 overlap, 1: 11001 non-overlap, 2: 111 overlap, 3: 111 non-overlap, 4: 111 overlap CNT_W=2
    seq_detector_param #(.SEQ_LEN(5), .PATTERN(5'b11001), .OVERLAP(1), .CNT_W(8)) u_a (
        .clk(clk), .reset(rst_n[0]), .in_valid(vld[0]), .in(din[0]), .out(o[0]), .match_cnt(cnt8[0]));
    seq_detector_param #(.SEQ_LEN(5), .PATTERN(5'b11001), .OVERLAP(0), .CNT_W(8)) u_b (
        .clk(clk), .reset(rst_n[1]), .in_valid(vld[1]), .in(din[1]), .out(o[1]), .match_cnt(cnt8[1]));
    seq_detector_param #(.SEQ_LEN(3), .PATTERN(3'b111), .OVERLAP(1), .CNT_W(8)) u_c (
        .clk(clk), .reset(rst_n[2]), .in_valid(vld[2]), .in(din[2]), .out(o[2]), .match_cnt(cnt8[2]));
    seq_detector_param #(.SEQ_LEN(3), .PATTERN(3'b111), .OVERLAP(0), .CNT_W(8)) u_d (
        .clk(clk), .reset(rst_n[3]), .in_valid(vld[3]), .in(din[3]), .out(o[3]), .match_cnt(cnt8[3]));
    seq_detector_param #(.SEQ_LEN(3), .PATTERN(3'b111), .OVERLAP(1), .CNT_W(2)) u_e (
        .clk(clk), .reset(rst_n[4]), .in_valid(vld[4]), .in(din[4]), .out(o[4]), .match_cnt(cnt2));

    function automatic int act_cnt(input int id);
        return (id == 4) ? int'(cnt2) : int'(cnt8[id]);
    endfunction

    // Monitor: compare every expectation due on this cycle.
    always begin
        @(posedge clk);
        #1;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            int   want_c;
            e = sb.pop_front();
`ifdef SEQ_DET_MATCH_CNT_EN
            want_c = e.ec;
`else
            want_c = 0;
`endif
            tests++;
            if (e.cyc != cyc || o[e.id] !== e.eo) begin
                fails++;
                $display("FAIL out inst=%0d cyc=%0d got %b want %b", e.id, cyc, o[e.id], e.eo);
            end
            tests++;
            if (act_cnt(e.id) != want_c) begin
                fails++;
                $display("FAIL match_cnt inst=%0d cyc=%0d got %0d want %0d",
                         e.id, cyc, act_cnt(e.id), want_c);
            end
        end
    end

    task automatic step(input int id, input logic r, input logic v, input logic b,
                        input logic eo, input int ec);
        exp_t e;
        @(negedge clk);
        rst_n[id] = r;
        vld[id]   = v;
        din[id]   = b;
        e.id  = id;
        e.cyc = cyc + 1;
        e.eo  = eo;
        e.ec  = ec;
        sb.push_back(e);
    endtask

    // Reset the instance for one cycle, then play qb with expectations qo/qc.
    task automatic run(input int id);
        step(id, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < qb.size(); i++) begin
            step(id, 1'b1, 1'b1, qb[i][0], qo[i][0], qc[i]);
        end
        @(negedge clk);
        vld[id] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got timeout want finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst_n[i] = 1'b0;
            vld[i]   = 1'b0;
            din[i]   = 1'b0;
        end
        for (int i = 0; i < NI; i++) begin
            step(i, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        end

        // 11001 overlapping: hits after bits 5 and 9
        qb = '{1,1,0,0,1,1,0,0,1};
        qo = '{0,0,0,0,1,0,0,0,1};
        qc = '{0,0,0,0,1,1,1,1,2};
        run(0);

        // 11001 non-overlapping: only bit 5
        qo = '{0,0,0,0,1,0,0,0,0};
        qc = '{0,0,0,0,1,1,1,1,1};
        run(1);

        // 111 overlapping, six ones
        qb = '{1,1,1,1,1,1};
        qo = '{0,0,1,1,1,1};
        qc = '{0,0,1,2,3,4};
        run(2);

        // 111 non-overlapping, six ones
        qo = '{0,0,1,0,0,1};
        qc = '{0,0,1,1,1,2};
        run(3);

        // Valid gaps: 1,1,0, three idle, 0,1, then two idle with out held
        step(0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        step(0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        step(0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        step(0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        step(0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        step(0, 1'b1, 1'b1, 1'b1, 1'b1, 1);
        for (int i = 0; i < 2; i++) step(0, 1'b1, 1'b0, 1'b1, 1'b1, 1);

        // Reset mid-sequence: 1,1,0,0, reset, 1 -> state 1, so 1,0,0,1 completes a match
        qb = '{1,1,0,0};
        qo = '{0,0,0,0};
        qc = '{0,0,0,0};
        run(0);
        step(0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        step(0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        step(0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        step(0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        step(0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        step(0, 1'b1, 1'b1, 1'b1, 1'b1, 1);

        // Saturation with a 2-bit counter, ten ones
        qb = '{1,1,1,1,1,1,1,1,1,1};
        qo = '{0,0,1,1,1,1,1,1,1,1};
        qc = '{0,0,1,2,3,3,3,3,3,3};
        run(4);

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
